// File: rtl/md_sequential_pipe_adder.sv
`default_nettype none
// ============================================================================
// md_sequential_pipe_adder: two-stage pipelined A+B+D adder, optional accumulate,
// wrap/saturate output, overflow flag and completed-sample counter.  Rev 1.0
// ============================================================================
module md_sequential_pipe_adder #(
    parameter int WIDTH = 2,
    parameter int OUT_W = 2,
    parameter int SAT   = 0,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IN_VALID,
    input  logic [WIDTH-1:0]   IN_A,
    input  logic [WIDTH-1:0]   IN_B,
    input  logic [WIDTH-1:0]   IN_D,
    input  logic               IN_ACC,
    output logic               OUT_A0,
    output logic               OUT_VALID,
    output logic [OUT_W-1:0]   OUT_E,
    output logic               OUT_OVF,
    output logic [CNT_W-1:0]   OUT_CNT
);

    localparam int TW = ((WIDTH + 2) > (OUT_W + 1) ? (WIDTH + 2) : (OUT_W + 1)) + 1;
    localparam logic [TW-1:0] MAX_T = {{(TW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic [WIDTH:0]   s1_q, s1_d;
    logic [WIDTH-1:0] d1_q, d1_d;
    logic             acc1_q, acc1_d;
    logic             v1_q;
    logic [OUT_W-1:0] e_q, e_d;
    logic             ovf_q, ovf_d;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [TW-1:0]    sum_t;
    logic             ovf_t;

    // Full-width total so the overflow compare never sees a truncated value.
    assign sum_t = TW'(s1_q) + TW'(d1_q) + (acc1_q ? TW'(e_q) : '0);
    assign ovf_t = (sum_t > MAX_T);

    always_comb begin
        s1_d   = s1_q;
        d1_d   = d1_q;
        acc1_d = acc1_q;
        e_d    = e_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        if (IN_VALID) begin
            s1_d   = {1'b0, IN_A} + {1'b0, IN_B};
            d1_d   = IN_D;
            acc1_d = IN_ACC;
        end
        if (v1_q) begin
            ovf_d = ovf_t;
            e_d   = ((SAT != 0) && ovf_t) ? {OUT_W{1'b1}} : sum_t[OUT_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            d1_q    <= '0;
            acc1_q  <= 1'b0;
            v1_q    <= 1'b0;
            e_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            d1_q    <= d1_d;
            acc1_q  <= acc1_d;
            v1_q    <= IN_VALID;
            e_q     <= e_d;
            ovf_q   <= ovf_d;
            valid_q <= v1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign OUT_A0    = IN_A[0];
    assign OUT_VALID = valid_q;
    assign OUT_E     = e_q;
    assign OUT_OVF   = ovf_q;
    assign OUT_CNT   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_md_sequential_pipe_adder.sv
`default_nettype none
// Bench for md_sequential_pipe_adder: three parameterisations driven in lockstep
// and checked against a per-sample arithmetic reference model.
module tb_md_sequential_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vin, acc;
    logic [3:0] a, b, d;

    logic       a0_0, v0, ovf0;  logic [1:0] e0;  logic [7:0] c0;
    logic       a0_1, v1, ovf1;  logic [1:0] e1;  logic [1:0] c1;
    logic       a0_2, v2, ovf2;  logic [7:0] e2;  logic [7:0] c2;

    md_sequential_pipe_adder #(.WIDTH(2), .OUT_W(2), .SAT(0), .CNT_W(8)) u_wrap (
        .clk(clk), .rst(rst), .IN_VALID(vin), .IN_A(a[1:0]), .IN_B(b[1:0]), .IN_D(d[1:0]),
        .IN_ACC(acc), .OUT_A0(a0_0), .OUT_VALID(v0), .OUT_E(e0), .OUT_OVF(ovf0), .OUT_CNT(c0));

    md_sequential_pipe_adder #(.WIDTH(2), .OUT_W(2), .SAT(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .IN_VALID(vin), .IN_A(a[1:0]), .IN_B(b[1:0]), .IN_D(d[1:0]),
        .IN_ACC(acc), .OUT_A0(a0_1), .OUT_VALID(v1), .OUT_E(e1), .OUT_OVF(ovf1), .OUT_CNT(c1));

    md_sequential_pipe_adder #(.WIDTH(4), .OUT_W(8), .SAT(0), .CNT_W(8)) u_wide (
        .clk(clk), .rst(rst), .IN_VALID(vin), .IN_A(a), .IN_B(b), .IN_D(d),
        .IN_ACC(acc), .OUT_A0(a0_2), .OUT_VALID(v2), .OUT_E(e2), .OUT_OVF(ovf2), .OUT_CNT(c2));

    // Reference model: one pending sample per DUT plus the last completed result.
    int W_P[3] = '{2, 2, 4};
    int O_P[3] = '{2, 2, 8};
    int S_P[3] = '{0, 1, 0};
    int C_P[3] = '{8, 2, 8};
    int me[3], mcnt[3], pa[3], pb[3], pd[3];
    bit mo[3], mv[3], pv[3], pacc[3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int wmask, omax, t;
            wmask = (1 << W_P[i]) - 1;
            omax  = (1 << O_P[i]) - 1;
            if (rst) begin
                me[i] = 0; mo[i] = 0; mv[i] = 0; mcnt[i] = 0; pv[i] = 0;
            end else begin
                if (pv[i]) begin
                    t      = pa[i] + pb[i] + pd[i] + (pacc[i] ? me[i] : 0);
                    mo[i]  = (t > omax);
                    me[i]  = (S_P[i] != 0) ? (mo[i] ? omax : t) : (t % (omax + 1));
                    mcnt[i] = (mcnt[i] + 1) % (1 << C_P[i]);
                    mv[i]  = 1;
                end else begin
                    mv[i] = 0;
                end
                pv[i] = vin;
                if (vin) begin
                    pa[i] = int'(a) & wmask; pb[i] = int'(b) & wmask; pd[i] = int'(d) & wmask;
                    pacc[i] = acc;
                end
            end
        end
    endtask

    task automatic check_dut(input int i, input logic v, input logic [31:0] e,
                             input logic o, input logic [31:0] c);
        chk($sformatf("dut%0d.valid", i), 32'(v), 32'(mv[i]));
        chk($sformatf("dut%0d.e", i), e, 32'(me[i]));
        chk($sformatf("dut%0d.ovf", i), 32'(o), 32'(mo[i]));
        chk($sformatf("dut%0d.cnt", i), c, 32'(mcnt[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_dut(0, v0, 32'(e0), ovf0, 32'(c0));
        check_dut(1, v1, 32'(e1), ovf1, 32'(c1));
        check_dut(2, v2, 32'(e2), ovf2, 32'(c2));
    endtask

    task automatic drive(input bit v, input bit ac, input int av, input int bv, input int dv);
        vin = v; acc = ac; a = 4'(av); b = 4'(bv); d = 4'(dv);
    endtask

    initial begin
        // Reset held with a valid sample presented: everything stays zero.
        rst = 1'b1;
        drive(1, 0, 3, 3, 3);
        tick(); tick();
        chk("rst.valid", 32'(v0), 0);
        chk("rst.e", 32'(e2), 0);
        chk("rst.cnt", 32'(c2), 0);

        // Wrap mode: 1+1+0 then 1+2+3.
        rst = 1'b0;
        drive(1, 0, 1, 1, 0); tick();
        chk("lat.novalid", 32'(v0), 0);
        drive(1, 0, 1, 2, 3); tick();
        chk("wrap1.valid", 32'(v0), 1);
        chk("wrap1.e", 32'(e0), 2);
        chk("wrap1.ovf", 32'(ovf0), 0);
        drive(0, 0, 0, 0, 0); tick();
        chk("wrap2.e", 32'(e0), 2);
        chk("wrap2.ovf", 32'(ovf0), 1);
        chk("sat_of6.e", 32'(e1), 3);
        chk("wide6.e", 32'(e2), 6);
        tick();
        chk("hold.valid", 32'(v0), 0);
        chk("hold.e", 32'(e0), 2);

        // Saturate mode, then an overflowing accumulate that must stay pinned.
        drive(1, 0, 3, 3, 3); tick();
        drive(1, 0, 0, 1, 1); tick();
        chk("sat1.e", 32'(e1), 3);
        chk("sat1.ovf", 32'(ovf1), 1);
        drive(1, 0, 3, 3, 3); tick();
        chk("sat2.e", 32'(e1), 2);
        chk("sat2.ovf", 32'(ovf1), 0);
        drive(1, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        chk("satacc.e", 32'(e1), 3);
        chk("satacc.ovf", 32'(ovf1), 1);

        // Back-to-back accumulate streaming from a fresh reset.
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1, k != 0, 10, 10, 10);
            tick();
            if (k >= 1) chk("accstream.e", 32'(e2), 32'(30 * k));
        end
        drive(0, 0, 0, 0, 0); tick();
        chk("accstream.final", 32'(e2), 150);
        chk("accstream.cnt", 32'(c2), 5);
        chk("accstream.ovf", 32'(ovf2), 0);

        // Gapped samples.
        drive(1, 0, 1, 1, 1); tick();
        drive(0, 0, 0, 0, 0); tick();
        chk("gap1.valid", 32'(v0), 1);
        chk("gap1.e", 32'(e0), 3);
        drive(1, 0, 2, 0, 0); tick();
        chk("gap2.valid", 32'(v0), 0);
        drive(0, 0, 0, 0, 0); tick();
        chk("gap3.valid", 32'(v0), 1);
        chk("gap3.e", 32'(e0), 2);

        // Reset one cycle after a capture flushes the in-flight sample.
        drive(1, 0, 3, 2, 1); tick();
        rst = 1'b1; drive(0, 0, 0, 0, 0); tick();
        rst = 1'b0; tick();
        chk("flush.valid", 32'(v2), 0);
        chk("flush.e", 32'(e2), 0);
        chk("flush.cnt", 32'(c2), 0);

        // Counter wrap on the 2-bit counter instance.
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, k, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0); tick();
        chk("cntwrap.c1", 32'(c1), 1);
        chk("cntwrap.c0", 32'(c0), 5);

        // Combinational passthrough of IN_A[0] while idle.
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, k, 0, 0);
            #1;
            chk("a0.dut0", 32'(a0_0), 32'(k & 1));
            chk("a0.dut1", 32'(a0_1), 32'(k & 1));
            chk("a0.dut2", 32'(a0_2), 32'(k & 1));
            tick();
        end

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
